pipe_stage_elastic: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake, a 2-entry skid buffer and synchronous flush.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_elastic_if.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_stage_elastic.sv | 117 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stages.
//   pipe_state_e   : occupancy of a stage (empty / one entry / main + skid entry)
//   fede_payload_t : fetch-to-decode payload {pc_next, instr}
//   NOP_INSTR      : decoder NOP encoding (addi x0, x0, 0)
//   FEDE_NOP       : bubble payload for the FE/DE stage
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_HALF,
    PS_FULL
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] instr;
  } fede_payload_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam fede_payload_t FEDE_NOP = '{pc_next: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready/data channel between two pipeline stages.
//   valid : producer has a payload on data
//   ready : consumer accepts this cycle
//   data  : payload, DATA_W bits
// master = producer side, slave = consumer side.
interface pipe_stage_elastic_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk : clock
//   clr : synchronous clear, wins over en
//   en  : count one event this cycle
//   q   : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cntQ;

  always_ff @(posedge clk) begin
    if (clr) begin
      cntQ <= '0;
    end else if (en && !(&cntQ)) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign q = cntQ;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register with a 2-entry skid buffer and flush.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high
//   flush     : synchronous kill of all held entries
//   inIf      : upstream channel (slave); inIf.ready is driven from state only
//   outIf     : downstream channel (master); data is NOP_VALUE when not valid
//   stall_cnt : cycles with out valid and not ready   (PIPE_STAGE_PERF_EN only)
//   flush_cnt : flush cycles that killed a held entry (PIPE_STAGE_PERF_EN only)
// Optional feature macro: PIPE_STAGE_PERF_EN adds the two saturating perf counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
`ifdef PIPE_STAGE_PERF_EN
  , parameter int unsigned     CNT_W     = 16
`endif
) (
  input logic clk,
  input logic rst,
  input logic flush,
  pipe_stage_elastic_if.slave  inIf,
  pipe_stage_elastic_if.master outIf
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  pipe_state_e       stateQ, stateD;
  logic [DATA_W-1:0] mainQ, mainD;
  logic [DATA_W-1:0] skidQ, skidD;
  logic              inReady, outValid, push, pop;

  // Ready comes from state (and rst) only, so back-pressure never forms a
  // combinational path from outIf.ready to inIf.ready.
  assign inReady  = (stateQ != PS_FULL) && !rst;
  assign outValid = (stateQ != PS_EMPTY);
  assign push     = inIf.valid && inReady;
  assign pop      = outValid && outIf.ready;

  always_comb begin
    stateD = stateQ;
    mainD  = mainQ;
    skidD  = skidQ;
    unique case (stateQ)
      PS_EMPTY: begin
        if (push) begin
          stateD = PS_HALF;
          mainD  = inIf.data;
        end
      end
      PS_HALF: begin
        if (push && !pop) begin
          stateD = PS_FULL;
          skidD  = inIf.data;
        end else if (push && pop) begin
          mainD = inIf.data;
        end else if (pop) begin
          stateD = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (pop) begin
          stateD = PS_HALF;
          mainD  = skidQ;
        end
      end
      default: stateD = PS_EMPTY;
    endcase
    // Flush only needs to empty the control state; any payload captured this
    // cycle is hidden by the output mux.
    if (flush) begin
      stateD = PS_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= PS_EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  // Payload registers carry no reset.
  always_ff @(posedge clk) begin
    mainQ <= mainD;
    skidQ <= skidD;
  end

  assign inIf.ready  = inReady;
  assign outIf.valid = outValid;
  assign outIf.data  = outValid ? mainQ : NOP_VALUE;

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .en (outValid && !outIf.ready),
    .q  (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .clr(rst),
    .en (flush && outValid),
    .q  (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (64-bit FE/DE payload, NOP bubble).
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam logic [63:0] NOP = FEDE_NOP;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.DATA_W(64)) upIf ();
  pipe_stage_elastic_if #(.DATA_W(64)) dnIf ();

`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] stallCnt, flushCnt;
`endif

  pipe_stage_elastic #(
    .DATA_W   (64),
    .NOP_VALUE(NOP)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W  (4)
`endif
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .inIf (upIf),
    .outIf(dnIf)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stallCnt),
    .flush_cnt(flushCnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        inV;
    logic [63:0] inD;
    logic        outR;
    logic        expInR;
    logic        expOutV;
    logic [63:0] expOutD;
    logic [3:0]  expFlushCnt;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [63:0] id,
                              input logic orr, input logic eir, input logic eov,
                              input logic [63:0] eod, input logic [3:0] efc);
    vec_t v;
    v.rst = r; v.flush = f; v.inV = iv; v.inD = id; v.outR = orr;
    v.expInR = eir; v.expOutV = eov; v.expOutD = eod; v.expFlushCnt = efc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [63:0] q[$];
  logic [63:0] nextVal;
  logic        r0, r1, inV, outR, mPush, mPop;

  initial begin
    //             rst f  inV data    outR inR outV data      flushCnt
    // reset held with in_valid high, then first push
    vecs[0]  = mk(1, 0, 1, 64'hA5,  0,   0,  0,   NOP,      0);
    vecs[1]  = mk(1, 0, 1, 64'hA5,  0,   0,  0,   NOP,      0);
    vecs[2]  = mk(1, 0, 1, 64'hA5,  0,   0,  0,   NOP,      0);
    vecs[3]  = mk(0, 0, 1, 64'hA5,  0,   1,  0,   NOP,      0);
    vecs[4]  = mk(0, 0, 0, 64'h0,   1,   1,  1,   64'hA5,   0);
    // streaming 1..8
    vecs[5]  = mk(0, 0, 1, 64'h1,   1,   1,  0,   NOP,      0);
    vecs[6]  = mk(0, 0, 1, 64'h2,   1,   1,  1,   64'h1,    0);
    vecs[7]  = mk(0, 0, 1, 64'h3,   1,   1,  1,   64'h2,    0);
    vecs[8]  = mk(0, 0, 1, 64'h4,   1,   1,  1,   64'h3,    0);
    vecs[9]  = mk(0, 0, 1, 64'h5,   1,   1,  1,   64'h4,    0);
    vecs[10] = mk(0, 0, 1, 64'h6,   1,   1,  1,   64'h5,    0);
    vecs[11] = mk(0, 0, 1, 64'h7,   1,   1,  1,   64'h6,    0);
    vecs[12] = mk(0, 0, 1, 64'h8,   1,   1,  1,   64'h7,    0);
    vecs[13] = mk(0, 0, 0, 64'h0,   1,   1,  1,   64'h8,    0);
    vecs[14] = mk(0, 0, 0, 64'h0,   0,   1,  0,   NOP,      0);
    // stall into the skid register, then release
    vecs[15] = mk(0, 0, 1, 64'h10,  0,   1,  0,   NOP,      0);
    vecs[16] = mk(0, 0, 1, 64'h11,  0,   1,  1,   64'h10,   0);
    vecs[17] = mk(0, 0, 1, 64'h12,  0,   0,  1,   64'h10,   0);
    vecs[18] = mk(0, 0, 1, 64'h12,  1,   0,  1,   64'h10,   0);
    vecs[19] = mk(0, 0, 1, 64'h12,  1,   1,  1,   64'h11,   0);
    vecs[20] = mk(0, 0, 0, 64'h0,   1,   1,  1,   64'h12,   0);
    // flush while FULL with 0x20 offered
    vecs[21] = mk(0, 0, 1, 64'h13,  0,   1,  0,   NOP,      0);
    vecs[22] = mk(0, 0, 1, 64'h14,  0,   1,  1,   64'h13,   0);
    vecs[23] = mk(0, 1, 1, 64'h20,  0,   0,  1,   64'h13,   0);
    vecs[24] = mk(0, 0, 1, 64'h21,  0,   1,  0,   NOP,      1);
    vecs[25] = mk(0, 0, 0, 64'h0,   1,   1,  1,   64'h21,   1);
    // flush in HALF with push+pop, then flush held while EMPTY
    vecs[26] = mk(0, 0, 1, 64'h30,  0,   1,  0,   NOP,      1);
    vecs[27] = mk(0, 1, 1, 64'h31,  1,   1,  1,   64'h30,   1);
    vecs[28] = mk(0, 1, 1, 64'h32,  1,   1,  0,   NOP,      2);
    vecs[29] = mk(0, 0, 0, 64'h0,   1,   1,  0,   NOP,      2);
    // reset mid-stream while FULL
    vecs[30] = mk(0, 0, 1, 64'h40,  0,   1,  0,   NOP,      2);
    vecs[31] = mk(0, 0, 1, 64'h41,  0,   1,  1,   64'h40,   2);
    vecs[32] = mk(1, 0, 1, 64'h42,  1,   0,  1,   64'h40,   2);
    vecs[33] = mk(0, 0, 0, 64'h0,   1,   1,  0,   NOP,      0);

    rst = 1'b1; flush = 1'b0;
    upIf.valid = 1'b0; upIf.data = '0; dnIf.ready = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 34; i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush;
      upIf.valid = vecs[i].inV; upIf.data = vecs[i].inD; dnIf.ready = vecs[i].outR;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(upIf.ready), 64'(vecs[i].expInR));
      check($sformatf("vec%0d_out_valid", i), 64'(dnIf.valid), 64'(vecs[i].expOutV));
      check($sformatf("vec%0d_out_data", i), dnIf.data, vecs[i].expOutD);
`ifdef PIPE_STAGE_PERF_EN
      check($sformatf("vec%0d_flush_cnt", i), 64'(flushCnt), 64'(vecs[i].expFlushCnt));
`endif
      @(posedge clk); #1;
    end

    // Random push/pop against a FIFO model; stage is EMPTY here.
    rst = 1'b0; flush = 1'b0;
    nextVal = 64'h100;
    for (int c = 0; c < 100; c++) begin
      dnIf.ready = 1'b0; #1; r0 = upIf.ready;
      dnIf.ready = 1'b1; #1; r1 = upIf.ready;
      check("rnd_in_ready_or0", 64'(r0), 64'(q.size() < 2));
      check("rnd_in_ready_or1", 64'(r1), 64'(q.size() < 2));
      check("rnd_out_valid", 64'(dnIf.valid), 64'(q.size() != 0));
      if (q.size() != 0) check("rnd_out_data", dnIf.data, q[0]);
      inV  = 1'($urandom_range(0, 1));
      outR = 1'($urandom_range(0, 3) != 0);
      upIf.valid = inV; upIf.data = nextVal; dnIf.ready = outR;
      mPush = inV && (q.size() < 2);
      mPop  = (q.size() != 0) && outR;
      @(posedge clk); #1;
      if (mPop) void'(q.pop_front());
      if (mPush) begin
        q.push_back(nextVal);
        nextVal = nextVal + 64'h1;
      end
    end

    rst = 1'b1; upIf.valid = 1'b0; dnIf.ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_out_valid", 64'(dnIf.valid), 64'h0);
    check("post_rst_out_data", dnIf.data, NOP);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation with a 4-bit counter.
    check("stall_cnt_start", 64'(stallCnt), 64'h0);
    upIf.valid = 1'b1; upIf.data = 64'h50;
    @(posedge clk); #1;
    upIf.valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    check("stall_cnt_10", 64'(stallCnt), 64'd10);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    check("stall_cnt_sat", 64'(stallCnt), 64'd15);
    check("stall_hold_data", dnIf.data, 64'h50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("stall_cnt_rst", 64'(stallCnt), 64'h0);
    check("flush_cnt_rst", 64'(flushCnt), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
